rpe_dbw: RTL and testbench
==========================

Name: rpe_dbw

Overview:
- Parametrised successor to the reduced-precision systolic PE.
- Computes one signed MAC per cycle using a packed low-bit weight code and an odd-expanded activation.
- Adds a double-buffered weight (shadow/active) so a new weight loads while the current one computes, plus a synchronous reset, valid tracking on every stream, an optional local-accumulate (output-stationary) mode and optional partial-sum saturation.
- Tiles into the SIZE x SIZE array as before: weights flow down, activations flow right, partial sums flow down.

Parameters:
SIZE, 8, array dimension; sets PSUM_W only.
ACT_W, 7, stored activation bits; expanded operand A is ACT_W+1 bits.
W_W, 5, weight code bits; MSB = mode flag M, low W_W-1 bits = signed Q.
MSR_SHIFT, 3, extra left shift applied when M=1.
PSUM_W, ACT_W+1+(W_W-1)+MSR_SHIFT+1+$clog2(SIZE) (=19), signed partial-sum width.
SATURATE, 0, 1 = clip the sum to the PSUM_W range; 0 = two's-complement wrap.

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
w_in  in  W_W  weight code from PE above
w_in_valid  in  1  load w_in into shadow register
w_swap_in  in  1  copy shadow into active weight
w_out  out  W_W  shadow register, to PE below
w_out_valid  out  1  w_in_valid delayed 1 cycle
w_swap_out  out  1  w_swap_in delayed 1 cycle
act_in  in  ACT_W  activation from left
act_in_valid  in  1  activation valid
act_out  out  ACT_W  registered act_in, to right
act_out_valid  out  1  registered act_in_valid
psum_in  in  PSUM_W  signed partial sum from above
psum_out  out  PSUM_W  signed result
psum_out_valid  out  1  psum_out updated this cycle
acc_mode  in  1  0 = weight-stationary pass-through; 1 = local accumulate
acc_clear  in  1  restart the local accumulator

Behaviour:
- Reset: all registers, including shadow, active, acc, every output and every valid, go to 0. rst has priority over every other input. Reset mid-load or mid-accumulate discards all state.
- Operand A = signed {act_in, 1'b1}, i.e. A = 2*act_in+1, range odd values -(2^ACT_W - 1)..(2^ACT_W - 1).
- Weight decode from the active register: M=0 gives Weff = 2Q+1; M=1 gives Weff = Q * 2^(MSR_SHIFT+1).
- Product P = A*Weff, exact and sign-extended to PSUM_W+1 bits.
- Weight path, each cycle:
  - if w_in_valid: shadow <= w_in.
  - if w_swap_in: active <= shadow value *before* this edge. A simultaneous load and swap gives the old shadow to active and the new w_in to shadow.
  - w_out = shadow; w_out_valid and w_swap_out are 1-cycle registered copies of their inputs.
  - This lets a column-wide swap ripple one row per cycle, matching the activation skew.
- Activation path: act_out <= act_in and act_out_valid <= act_in_valid every cycle, independent of weight activity. Unlike the previous PE, loading does not freeze the pipe.
- MAC, latency 1 cycle, when act_in_valid=1:
  - The MAC uses the active weight *before* any same-cycle swap.
  - acc_mode=0: psum_out <= sat(psum_in + P).
  - acc_mode=1: acc <= sat((acc_clear ? 0 : acc) + P); psum_out <= that same value. psum_in is ignored.
  - psum_out_valid <= 1 in both modes.
- act_in_valid=0: psum_out holds its value and psum_out_valid <= 0. acc_clear with acc_mode=1 sets acc <= 0 and leaves psum_out unchanged.
- sat(): the sum is formed at PSUM_W+1 bits.
  - SATURATE=1: clamp to [-2^(PSUM_W-1), 2^(PSUM_W-1)-1].
  - SATURATE=0: keep the low PSUM_W bits.
- Changing acc_mode takes effect on the next valid; acc is not cleared by the mode change.

Test Plan:
- Reset then idle: rst=1 for 2 cycles with random inputs -> every output and valid reads 0 during and after reset.
- Load w_in=5'b00010 (M=0, Q=2), swap next cycle, then act_in=3, psum_in=100, valid -> one cycle later psum_out=135 (7*5+100), psum_out_valid=1, act_out=3, w_out_valid/w_swap_out each high one cycle after their inputs.
- Active weight 5'b00010, in the same cycle load w_in=5'b11111 (M=1, Q=-1), pulse swap and issue act_in=3, psum_in=0 -> psum_out=35 (old active weight). Next valid with act_in=3 -> psum_out=-112; w_out=5'b11111.
- Accumulate: acc_mode=1, weight Q=2 M=0, act_in=3 for 3 valids with acc_clear on the first -> psum_out 35, 70, 105. Then acc_clear without valid followed by one valid -> psum_out=35.
- Saturation: weight 5'b00010, act_in=3, psum_in=262143. SATURATE=1 -> psum_out=262143. SATURATE=0 -> psum_out=-262110.
- Bubbles and reset mid-accumulate: alternate valid/invalid activations -> psum_out holds and psum_out_valid toggles. Assert rst between accumulations -> the next accumulate restarts from 0 and the weight reads as 0, so Weff=1 and psum_out=A.

Source files
------------

// File: rtl/rpe_dbw.sv
// rpe_dbw: reduced-precision systolic PE with a double-buffered (shadow/active) weight.
// Latency: 1 cycle from act_in/act_in_valid to psum_out/psum_out_valid and to every pass-through output.
// Backpressure: none. All streams are valid-only and are accepted every cycle.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset (clears all state)
//   w_in / w_in_valid        weight code from the PE above; loads the shadow register
//   w_swap_in                copies shadow into active (uses the shadow value from before the edge)
//   w_out / w_out_valid      shadow register and delayed load strobe, to the PE below
//   w_swap_out               w_swap_in delayed one cycle, so a column swap ripples one row per cycle
//   act_in / act_in_valid    activation from the left
//   act_out / act_out_valid  registered activation, to the right
//   psum_in                  signed partial sum from above
//   psum_out/psum_out_valid  signed result, updated only on a valid activation
//   acc_mode, acc_clear      0 = pass-through sum; 1 = local accumulate; clear restarts the accumulator
module rpe_dbw #(
  parameter int SIZE      = 8,
  parameter int ACT_W     = 7,
  parameter int W_W       = 5,
  parameter int MSR_SHIFT = 3,
  parameter int PSUM_W    = ACT_W + 1 + (W_W - 1) + MSR_SHIFT + 1 + $clog2(SIZE),
  parameter int SATURATE  = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [W_W-1:0]    w_in,
  input  logic              w_in_valid,
  input  logic              w_swap_in,
  output logic [W_W-1:0]    w_out,
  output logic              w_out_valid,
  output logic              w_swap_out,
  input  logic [ACT_W-1:0]  act_in,
  input  logic              act_in_valid,
  output logic [ACT_W-1:0]  act_out,
  output logic              act_out_valid,
  input  logic [PSUM_W-1:0] psum_in,
  output logic [PSUM_W-1:0] psum_out,
  output logic              psum_out_valid,
  input  logic              acc_mode,
  input  logic              acc_clear
);

  // Operand widths. The PSUM_W default leaves log2(SIZE) guard bits above the
  // product, and one more bit is added for the sum so overflow is detectable.
  localparam int A_W    = ACT_W + 1;
  localparam int Q_W    = W_W - 1;
  localparam int WEFF_W = Q_W + MSR_SHIFT + 1;
  localparam int P_W    = A_W + WEFF_W;
  localparam int S_W    = PSUM_W + 1;

  logic [W_W-1:0]    shadow;
  logic [W_W-1:0]    active;
  logic [PSUM_W-1:0] acc;

  // Weight decode, always from the active register as it stands before any
  // swap on this edge.
  logic                     mode_m;
  logic signed [Q_W-1:0]    q;
  logic signed [WEFF_W-1:0] q_ext;
  logic signed [WEFF_W-1:0] weff;

  assign mode_m = active[W_W-1];
  assign q      = active[Q_W-1:0];
  assign q_ext  = {{(WEFF_W - Q_W){q[Q_W-1]}}, q};

  always_comb begin
    weff = '0;
    if (mode_m) begin
      // Q * 2^(MSR_SHIFT+1): Q fits in Q_W bits, so the shift fits WEFF_W exactly.
      weff = q_ext <<< (MSR_SHIFT + 1);
    end else begin
      // 2Q+1: odd weight, the low bit is implied.
      weff = {q_ext[WEFF_W-2:0], 1'b1};
    end
  end

  // Odd-expanded activation: A = 2*act_in + 1.
  logic signed [A_W-1:0] a_op;
  assign a_op = {act_in, 1'b1};

  // Exact product; both operands are signed, so they extend to P_W bits.
  logic signed [P_W-1:0] prod;
  assign prod = a_op * weff;

  logic signed [S_W-1:0] prod_ext;
  assign prod_ext = {{(S_W - P_W){prod[P_W-1]}}, prod};

  // Addend: incoming partial sum in pass-through mode, local accumulator
  // (or zero on clear) in accumulate mode.
  logic [PSUM_W-1:0]     base;
  logic signed [S_W-1:0] base_ext;
  logic signed [S_W-1:0] sum;

  always_comb begin
    base = psum_in;
    if (acc_mode) begin
      base = acc_clear ? '0 : acc;
    end
  end

  assign base_ext = {base[PSUM_W-1], base};
  assign sum      = base_ext + prod_ext;

  // Overflow at PSUM_W shows up as the top two bits of the PSUM_W+1 sum
  // disagreeing; the sign bit then tells which rail to clamp to.
  logic [PSUM_W-1:0] psum_max;
  logic [PSUM_W-1:0] psum_min;
  logic [PSUM_W-1:0] mac_res;

  assign psum_max = {1'b0, {(PSUM_W - 1){1'b1}}};
  assign psum_min = {1'b1, {(PSUM_W - 1){1'b0}}};

  always_comb begin
    mac_res = sum[PSUM_W-1:0];
    if ((SATURATE != 0) && (sum[S_W-1] != sum[S_W-2])) begin
      mac_res = sum[S_W-1] ? psum_min : psum_max;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shadow         <= '0;
      active         <= '0;
      acc            <= '0;
      w_out_valid    <= 1'b0;
      w_swap_out     <= 1'b0;
      act_out        <= '0;
      act_out_valid  <= 1'b0;
      psum_out       <= '0;
      psum_out_valid <= 1'b0;
    end else begin
      // Non-blocking reads give the pre-edge shadow to active, so a load and
      // swap in the same cycle moves the old shadow and parks the new code.
      if (w_in_valid) begin
        shadow <= w_in;
      end
      if (w_swap_in) begin
        active <= shadow;
      end
      w_out_valid <= w_in_valid;
      w_swap_out  <= w_swap_in;

      // The activation pipe never stalls, whatever the weight path is doing.
      act_out       <= act_in;
      act_out_valid <= act_in_valid;

      psum_out_valid <= act_in_valid;
      if (act_in_valid) begin
        psum_out <= mac_res;
        if (acc_mode) begin
          acc <= mac_res;
        end
      end else if (acc_mode && acc_clear) begin
        acc <= '0;
      end
    end
  end

  assign w_out = shadow;

endmodule

// File: tb/tb_rpe_dbw.sv
module tb_rpe_dbw;

  localparam int ACT_W  = 7;
  localparam int W_W    = 5;
  localparam int PSUM_W = 19;

  logic              clk = 1'b0;
  logic              rst;
  logic [W_W-1:0]    w_in;
  logic              w_in_valid;
  logic              w_swap_in;
  logic [ACT_W-1:0]  act_in;
  logic              act_in_valid;
  logic [PSUM_W-1:0] psum_in;
  logic              acc_mode;
  logic              acc_clear;

  // Wrapping instance
  logic [W_W-1:0]           w_out;
  logic                     w_out_valid, w_swap_out;
  logic [ACT_W-1:0]         act_out;
  logic                     act_out_valid;
  logic signed [PSUM_W-1:0] psum_out;
  logic                     psum_out_valid;

  // Saturating instance
  logic [W_W-1:0]           w_out_s;
  logic                     w_out_valid_s, w_swap_out_s;
  logic [ACT_W-1:0]         act_out_s;
  logic                     act_out_valid_s;
  logic signed [PSUM_W-1:0] psum_out_s;
  logic                     psum_out_valid_s;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  rpe_dbw #(.SATURATE(0)) dut (
    .clk(clk), .rst(rst),
    .w_in(w_in), .w_in_valid(w_in_valid), .w_swap_in(w_swap_in),
    .w_out(w_out), .w_out_valid(w_out_valid), .w_swap_out(w_swap_out),
    .act_in(act_in), .act_in_valid(act_in_valid),
    .act_out(act_out), .act_out_valid(act_out_valid),
    .psum_in(psum_in), .psum_out(psum_out), .psum_out_valid(psum_out_valid),
    .acc_mode(acc_mode), .acc_clear(acc_clear)
  );

  rpe_dbw #(.SATURATE(1)) dut_s (
    .clk(clk), .rst(rst),
    .w_in(w_in), .w_in_valid(w_in_valid), .w_swap_in(w_swap_in),
    .w_out(w_out_s), .w_out_valid(w_out_valid_s), .w_swap_out(w_swap_out_s),
    .act_in(act_in), .act_in_valid(act_in_valid),
    .act_out(act_out_s), .act_out_valid(act_out_valid_s),
    .psum_in(psum_in), .psum_out(psum_out_s), .psum_out_valid(psum_out_valid_s),
    .acc_mode(acc_mode), .acc_clear(acc_clear)
  );

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".w_out"}, 32'(w_out), 0);
    chk({tag, ".w_out_valid"}, 32'(w_out_valid), 0);
    chk({tag, ".w_swap_out"}, 32'(w_swap_out), 0);
    chk({tag, ".act_out"}, 32'(act_out), 0);
    chk({tag, ".act_out_valid"}, 32'(act_out_valid), 0);
    chk({tag, ".psum_out"}, 32'(psum_out), 0);
    chk({tag, ".psum_out_valid"}, 32'(psum_out_valid), 0);
    chk({tag, ".psum_out_s"}, 32'(psum_out_s), 0);
    chk({tag, ".psum_out_valid_s"}, 32'(psum_out_valid_s), 0);
  endtask

  task automatic idle_inputs();
    rst = 1'b0; w_in = '0; w_in_valid = 1'b0; w_swap_in = 1'b0;
    act_in = '0; act_in_valid = 1'b0; psum_in = '0;
    acc_mode = 1'b0; acc_clear = 1'b0;
  endtask

  initial begin
    idle_inputs();
    #2;

    // Reset with random inputs for two cycles, then idle.
    for (int i = 0; i < 2; i++) begin
      rst = 1'b1;
      w_in = W_W'($urandom); w_in_valid = 1'($urandom); w_swap_in = 1'($urandom);
      act_in = ACT_W'($urandom); act_in_valid = 1'($urandom);
      psum_in = PSUM_W'($urandom); acc_mode = 1'($urandom); acc_clear = 1'($urandom);
      tick();
      chk_all_zero("rst");
    end
    idle_inputs();
    tick();
    chk_all_zero("post_rst");

    // Load M=0 Q=2, swap next cycle, then a valid MAC: 7*5+100 = 135.
    w_in = 5'b00010; w_in_valid = 1'b1;
    tick();
    chk("load.w_out", 32'(w_out), 2);
    chk("load.w_out_valid", 32'(w_out_valid), 1);
    w_in_valid = 1'b0; w_swap_in = 1'b1;
    tick();
    chk("swap.w_swap_out", 32'(w_swap_out), 1);
    chk("swap.w_out_valid", 32'(w_out_valid), 0);
    w_swap_in = 1'b0; act_in = 7'd3; act_in_valid = 1'b1; psum_in = 19'd100;
    tick();
    chk("mac1.psum_out", 32'(psum_out), 135);
    chk("mac1.psum_out_valid", 32'(psum_out_valid), 1);
    chk("mac1.act_out", 32'(act_out), 3);
    chk("mac1.act_out_valid", 32'(act_out_valid), 1);
    chk("mac1.w_swap_out", 32'(w_swap_out), 0);

    // Load 11111 + swap + valid in one cycle: MAC uses old active (Weff=5),
    // active takes the old shadow (still 00010), shadow takes 11111.
    w_in = 5'b11111; w_in_valid = 1'b1; w_swap_in = 1'b1; psum_in = '0;
    tick();
    chk("dbl.psum_out", 32'(psum_out), 35);
    chk("dbl.w_out", 32'(w_out), 31);
    // Swap again with a valid: MAC still sees 00010 before the edge.
    w_in_valid = 1'b0;
    tick();
    chk("dbl2.psum_out", 32'(psum_out), 35);
    chk("dbl2.w_out_valid", 32'(w_out_valid), 0);
    // Active is now M=1 Q=-1: Weff=-16, 7*-16 = -112.
    w_swap_in = 1'b0;
    tick();
    chk("msr.psum_out", 32'(psum_out), -112);
    chk("msr.w_out", 32'(w_out), 31);

    // Back to M=0 Q=2.
    act_in_valid = 1'b0; w_in = 5'b00010; w_in_valid = 1'b1;
    tick();
    chk("reload.psum_valid", 32'(psum_out_valid), 0);
    chk("reload.psum_hold", 32'(psum_out), -112);
    w_in_valid = 1'b0; w_swap_in = 1'b1;
    tick();
    w_swap_in = 1'b0;

    // Accumulate 3 valids, clear on the first; psum_in must be ignored.
    acc_mode = 1'b1; acc_clear = 1'b1; act_in = 7'd3; act_in_valid = 1'b1; psum_in = 19'd999;
    tick();
    chk("acc1.psum_out", 32'(psum_out), 35);
    acc_clear = 1'b0;
    tick();
    chk("acc2.psum_out", 32'(psum_out), 70);
    tick();
    chk("acc3.psum_out", 32'(psum_out), 105);
    chk("acc3.psum_out_s", 32'(psum_out_s), 105);
    // Clear without a valid: output holds, accumulator restarts.
    acc_clear = 1'b1; act_in_valid = 1'b0;
    tick();
    chk("accclr.psum_out", 32'(psum_out), 105);
    chk("accclr.psum_out_valid", 32'(psum_out_valid), 0);
    acc_clear = 1'b0; act_in_valid = 1'b1;
    tick();
    chk("accrst.psum_out", 32'(psum_out), 35);

    // Saturation, positive: 262143 + 35.
    acc_mode = 1'b0; psum_in = 19'd262143;
    tick();
    chk("satp.wrap", 32'(psum_out), -262110);
    chk("satp.clip", 32'(psum_out_s), 262143);
    // Saturation, negative: act=-1 -> A=-1, P=-5; -262144 - 5.
    act_in = 7'h7f; psum_in = 19'h40000;
    tick();
    chk("satn.wrap", 32'(psum_out), 262139);
    chk("satn.clip", 32'(psum_out_s), -262144);

    // Bubbles: act=1 -> A=3, P=15; act=2 -> A=5, P=25.
    act_in = 7'd1; psum_in = 19'd10;
    tick();
    chk("bub1.psum_out", 32'(psum_out), 25);
    chk("bub1.valid", 32'(psum_out_valid), 1);
    act_in_valid = 1'b0; act_in = 7'd9; psum_in = 19'd500;
    tick();
    chk("bub2.psum_hold", 32'(psum_out), 25);
    chk("bub2.valid", 32'(psum_out_valid), 0);
    chk("bub2.act_out", 32'(act_out), 9);
    chk("bub2.act_out_valid", 32'(act_out_valid), 0);
    act_in_valid = 1'b1; act_in = 7'd2; psum_in = 19'd1;
    tick();
    chk("bub3.psum_out", 32'(psum_out), 26);
    chk("bub3.valid", 32'(psum_out_valid), 1);
    act_in_valid = 1'b0;
    tick();
    chk("bub4.psum_hold", 32'(psum_out), 26);
    chk("bub4.valid", 32'(psum_out_valid), 0);

    // Reset mid-accumulate: state discarded, weight reads 0 -> Weff=1.
    acc_mode = 1'b1; acc_clear = 1'b1; act_in = 7'd3; act_in_valid = 1'b1;
    tick();
    chk("racc1.psum_out", 32'(psum_out), 35);
    acc_clear = 1'b0;
    tick();
    chk("racc2.psum_out", 32'(psum_out), 70);
    rst = 1'b1;
    tick();
    chk_all_zero("midrst");
    rst = 1'b0;
    tick();
    chk("racc3.psum_out", 32'(psum_out), 7);
    chk("racc3.psum_out_s", 32'(psum_out_s), 7);
    chk("racc3.w_out", 32'(w_out), 0);
    tick();
    chk("racc4.psum_out", 32'(psum_out), 14);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
